// File: rtl/mul_accumulator_if.sv
// Product-intake and result handshakes of the multiply-accumulate path.
// Group clear and the group progress count travel with the handshakes.
interface mul_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int N      = 4
);
    localparam int CNT_W = $clog2(N + 1);

    logic              clr;
    logic              p_valid;
    logic [PROD_W-1:0] p_data;
    logic              p_ready;
    logic              acc_valid;
    logic              acc_ready;
    logic [ACC_W-1:0]  acc_data;
    logic              ovf;
    logic [CNT_W-1:0]  cnt;

    modport master (
        output clr, p_valid, p_data, acc_ready,
        input  p_ready, acc_valid, acc_data, ovf, cnt
    );

    modport slave (
        input  clr, p_valid, p_data, acc_ready,
        output p_ready, acc_valid, acc_data, ovf, cnt
    );
endinterface

// File: rtl/mul_accumulator.sv
// Sums N consecutive unsigned products into one saturating accumulator word
// and presents each group sum over a valid/ready handshake.
module mul_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int N      = 4
) (
    input logic               clk,
    input logic               rst,
    mul_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic               acc_valid_q;
    logic [ACC_W:0]     sat_res;
    logic [CNT_W-1:0]   cnt_inc;

    // Returns {carry, value}; on carry-out the value is pinned to all ones.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] p);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
        if (s[ACC_W]) begin
            s = {1'b1, {ACC_W{1'b1}}};
        end
        return s;
    endfunction

    always_comb begin
        sat_res = sat_add(acc, bus.p_data);
        cnt_inc = cnt_q + 1'b1;
    end

    assign bus.p_ready   = (state != HOLD);
    assign bus.acc_valid = acc_valid_q;
    assign bus.acc_data  = acc;
    assign bus.ovf       = ovf_q;
    assign bus.cnt       = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            acc_valid_q <= 1'b0;
        end else if (bus.clr) begin
            // Clear wins over any same-cycle product or result handshake.
            state       <= IDLE;
            acc         <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            acc_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (bus.p_valid) begin
                        acc   <= sat_res[ACC_W-1:0];
                        ovf_q <= ovf_q | sat_res[ACC_W];
                        cnt_q <= cnt_inc;
                        if (cnt_inc == N_CNT) begin
                            state       <= HOLD;
                            acc_valid_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (bus.acc_ready) begin
                        state       <= IDLE;
                        acc         <= '0;
                        cnt_q       <= '0;
                        ovf_q       <= 1'b0;
                        acc_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    acc         <= '0;
                    cnt_q       <= '0;
                    ovf_q       <= 1'b0;
                    acc_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
